// File: rtl/obi_mem_responder.sv
// OBI subordinate scratchpad: byte-enabled word array with optional wait states
// before grant and out-of-range decode. Define OBI_MEM_RESPONDER_ERR_EN to add obi_err_o.
module obi_mem_responder #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           MEM_ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h00080000,
    parameter int unsigned           WAIT_STATES    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  obi_req_i,
    output logic                  obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0] obi_addr_i,
    input  logic                  obi_we_i,
    input  logic [3:0]            obi_be_i,
    input  logic [DATA_WIDTH-1:0] obi_wdata_i,
    output logic                  obi_rvalid_o,
    output logic [DATA_WIDTH-1:0] obi_rdata_o,
`ifdef OBI_MEM_RESPONDER_ERR_EN
    output logic                  obi_err_o,
`endif
    output logic                  busy_o
);

    localparam int unsigned DEPTH = 2 ** MEM_ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~((ADDR_WIDTH'(1) << (MEM_ADDR_WIDTH + 2)) - ADDR_WIDTH'(1));
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] be_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [3:0]            be
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    function automatic logic multi_be(input logic [3:0] be);
        return (be & (be - 4'd1)) != 4'd0;
    endfunction

    logic [DATA_WIDTH-1:0]     mem_r [DEPTH];
    state_t                    state_r;
    state_t                    next_state_s;
    logic [3:0]                cnt_r;
    logic [3:0]                next_cnt_s;
    logic                      gnt_s;
    logic                      accept_s;
    logic                      hit_s;
    logic                      wr_en_s;
    logic [MEM_ADDR_WIDTH-1:0] idx_s;
    logic                      rvalid_r;
    logic [DATA_WIDTH-1:0]     rdata_r;
    logic                      busy_r;

    assign hit_s    = (obi_addr_i & ADDR_MASK) == BASE_ADDR;
    assign idx_s    = obi_addr_i[MEM_ADDR_WIDTH+1:2];
    assign accept_s = obi_req_i & gnt_s;

`ifdef OBI_MEM_RESPONDER_ERR_EN
    logic misaligned_s;
    logic err_r;
    assign misaligned_s = (obi_addr_i[1:0] != 2'b00) & multi_be(obi_be_i);
    assign wr_en_s      = accept_s & obi_we_i & hit_s & ~misaligned_s;
    assign obi_err_o    = err_r & ~rst_i;

    // Error flag travels alongside rvalid for misses and misaligned accesses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= accept_s & (~hit_s | misaligned_s);
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{obi_addr_i[1:0], multi_be(obi_be_i)};
    assign wr_en_s  = accept_s & obi_we_i & hit_s;
`endif

    // Grant FSM: combinational grant in IDLE when no wait states, counted WAIT otherwise.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        gnt_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (WAIT_STATES == 0) begin
                    gnt_s = obi_req_i;
                end else if (obi_req_i) begin
                    next_state_s = ST_WAIT;
                    next_cnt_s   = WAIT_INIT;
                end else begin
                    next_cnt_s = 4'd0;
                end
            end
            ST_WAIT: begin
                if (!obi_req_i) begin
                    // Initiator withdrew the request; abandon it silently.
                    next_state_s = ST_IDLE;
                    next_cnt_s   = 4'd0;
                end else if (cnt_r != 4'd0) begin
                    next_cnt_s = cnt_r - 4'd1;
                end else begin
                    gnt_s        = 1'b1;
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_cnt_s   = 4'd0;
            end
        endcase
        if (rst_i) begin
            gnt_s = 1'b0;
        end else begin
            gnt_s = gnt_s;
        end
    end

    // State, counter and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= next_cnt_s;
            rvalid_r <= accept_s;
            rdata_r  <= (accept_s & ~obi_we_i & hit_s) ? mem_r[idx_s] : {DATA_WIDTH{1'b0}};
            busy_r   <= (next_state_s == ST_WAIT) | accept_s;
        end
    end

    // Storage array, byte-enabled writes on the accept edge; not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[idx_s] <= be_merge(mem_r[idx_s], obi_wdata_i, obi_be_i);
        end
    end

    // Reset kills a pending response in the same cycle it is asserted.
    assign obi_gnt_o    = gnt_s;
    assign obi_rvalid_o = rvalid_r & ~rst_i;
    assign obi_rdata_o  = rst_i ? {DATA_WIDTH{1'b0}} : rdata_r;
    assign busy_o       = busy_r;

endmodule
